// File: rtl/accel_mem_arbiter_pkg.sv
// Shared types for the accelerator/LSQ data-cache arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which initiator owns the in-flight dcache transaction
//   GNT_*       : bit positions in the pending/grant vectors
// The round-robin option (ACCEL_MEM_ARB_RR_EN) does not change this package.
package accel_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_LSQ   = 2'd1,
      OWN_ACCEL = 2'd2
   } arb_owner_t;

   localparam int unsigned GNT_LSQ   = 0;
   localparam int unsigned GNT_ACCEL = 1;

endpackage

// File: rtl/accel_mem_arbiter_arb_grant.sv
// Grant selection between LSQ and accelerator.
// Ports:
//   clk, reset : clock / synchronous active-high reset (round-robin build only)
//   take_i     : the arbiter is able to accept a grant this cycle (round-robin build only)
//   pend_i     : pending request per initiator, [GNT_LSQ] and [GNT_ACCEL]
//   grant_o    : one-hot grant (all zero when nothing is pending)
// Macro ACCEL_MEM_ARB_RR_EN: defined -> round-robin with a one-bit pointer,
// undefined -> fixed priority, LSQ over accelerator, no pointer state.
module accel_mem_arbiter_arb_grant
   import accel_mem_arbiter_pkg::*;
(
`ifdef ACCEL_MEM_ARB_RR_EN
   input  logic       clk,
   input  logic       reset,
   input  logic       take_i,
`endif
   input  logic [1:0] pend_i,
   output logic [1:0] grant_o
);

`ifdef ACCEL_MEM_ARB_RR_EN
   // ptr_q = 0 favours LSQ, 1 favours accelerator on a tie.
   logic ptr_q;

   always_comb begin
      grant_o = pend_i;
      if (pend_i == 2'b11) begin
         grant_o = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After each grant the pointer favours the initiator that just lost out.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else if (take_i && (grant_o != 2'b00)) begin
         ptr_q <= grant_o[GNT_LSQ];
      end
   end
`else
   always_comb begin
      grant_o = pend_i;
      if (pend_i[GNT_LSQ]) begin
         grant_o[GNT_ACCEL] = 1'b0;
      end
   end
`endif

endmodule

// File: rtl/accel_mem_arbiter.sv
// Arbitrates LSQ and accelerator load/store requests onto the single
// data-cache port. One transaction in flight, no reordering; the owner gets
// a one-cycle resp pulse with the latched read data.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   lsq_read/write/address/wdata/mbe   : LSQ request, held until lsq_resp
//   lsq_resp, lsq_rdata                : LSQ completion pulse and read data
//   accel_read/write/address/st_data   : accelerator word request, held until accel_resp
//   accel_resp, accel_data             : accelerator completion pulse and read data
//   dmem_read/write/address/wdata/mbe  : registered dcache request
//   dmem_resp, dmem_rdata              : dcache completion pulse and read data
// Macro ACCEL_MEM_ARB_RR_EN selects round-robin grant; default is LSQ priority.
module accel_mem_arbiter
   import accel_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                lsq_read,
   input  logic                lsq_write,
   input  logic [ADDR_W-1:0]   lsq_address,
   input  logic [DATA_W-1:0]   lsq_wdata,
   input  logic [DATA_W/8-1:0] lsq_mbe,
   output logic                lsq_resp,
   output logic [DATA_W-1:0]   lsq_rdata,
   input  logic                accel_read,
   input  logic                accel_write,
   input  logic [ADDR_W-1:0]   accel_address,
   input  logic [DATA_W-1:0]   accel_st_data,
   output logic                accel_resp,
   output logic [DATA_W-1:0]   accel_data,
   output logic                dmem_read,
   output logic                dmem_write,
   output logic [ADDR_W-1:0]   dmem_address,
   output logic [DATA_W-1:0]   dmem_wdata,
   output logic [DATA_W/8-1:0] dmem_mbe,
   input  logic                dmem_resp,
   input  logic [DATA_W-1:0]   dmem_rdata
);

   localparam int MBE_W = DATA_W / 8;

   arb_state_t        state_q;
   arb_owner_t        owner_q;
   logic              dmem_read_q;
   logic              dmem_write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MBE_W-1:0]  mbe_q;
   logic [DATA_W-1:0] rdata_q;
   logic              lsq_resp_q;
   logic              accel_resp_q;

   logic [1:0]        pend;
   logic [1:0]        grant;
   logic              take;
   logic              unused_accel_lsb;

   assign pend[GNT_LSQ]   = lsq_read | lsq_write;
   assign pend[GNT_ACCEL] = accel_read | accel_write;
   assign take            = (state_q == ARB_IDLE);
   // Accelerator accesses are whole words; the byte offset is dropped.
   assign unused_accel_lsb = ^accel_address[1:0];

   accel_mem_arbiter_arb_grant u_arb_grant (
`ifdef ACCEL_MEM_ARB_RR_EN
      .clk     (clk),
      .reset   (reset),
      .take_i  (take),
`endif
      .pend_i  (pend),
      .grant_o (grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWN_NONE;
         dmem_read_q  <= 1'b0;
         dmem_write_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mbe_q        <= '0;
         rdata_q      <= '0;
         lsq_resp_q   <= 1'b0;
         accel_resp_q <= 1'b0;
      end else begin
         lsq_resp_q   <= 1'b0;
         accel_resp_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               // read and write together count as a write
               if (grant[GNT_LSQ]) begin
                  owner_q      <= OWN_LSQ;
                  dmem_write_q <= lsq_write;
                  dmem_read_q  <= lsq_read & ~lsq_write;
                  addr_q       <= lsq_address;
                  wdata_q      <= lsq_wdata;
                  mbe_q        <= lsq_mbe;
                  state_q      <= ARB_BUSY;
               end else if (grant[GNT_ACCEL]) begin
                  owner_q      <= OWN_ACCEL;
                  dmem_write_q <= accel_write;
                  dmem_read_q  <= accel_read & ~accel_write;
                  addr_q       <= {accel_address[ADDR_W-1:2], 2'b00};
                  wdata_q      <= accel_st_data;
                  mbe_q        <= '1;
                  state_q      <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (dmem_resp) begin
                  rdata_q      <= dmem_rdata;
                  dmem_read_q  <= 1'b0;
                  dmem_write_q <= 1'b0;
                  lsq_resp_q   <= (owner_q == OWN_LSQ);
                  accel_resp_q <= (owner_q == OWN_ACCEL);
                  state_q      <= ARB_RESP;
               end
            end
            // RESP exists so the owner, still holding its request while it
            // sees resp, is not granted a second time.
            ARB_RESP: begin
               owner_q <= OWN_NONE;
               state_q <= ARB_IDLE;
            end
            default: begin
               owner_q <= OWN_NONE;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign dmem_read    = dmem_read_q;
   assign dmem_write   = dmem_write_q;
   assign dmem_address = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_mbe     = mbe_q;
   assign lsq_resp     = lsq_resp_q;
   assign lsq_rdata    = rdata_q;
   assign accel_resp   = accel_resp_q;
   assign accel_data   = rdata_q;

   a_lsq_rw_excl: assert property (@(posedge clk) disable iff (reset)
      !(lsq_read && lsq_write));
   a_accel_rw_excl: assert property (@(posedge clk) disable iff (reset)
      !(accel_read && accel_write));
   a_resp_only_busy: assert property (@(posedge clk) disable iff (reset)
      dmem_resp |-> (state_q == ARB_BUSY));

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Self-checking bench for accel_mem_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
// Honours ACCEL_MEM_ARB_RR_EN for the expected grant order.
module tb_accel_mem_arbiter;

   localparam int WAIT_MAX = 80;

   logic        clk = 1'b0;
   logic        reset;
   logic        lsq_read, lsq_write;
   logic [31:0] lsq_address, lsq_wdata;
   logic [3:0]  lsq_mbe;
   logic        lsq_resp;
   logic [31:0] lsq_rdata;
   logic        accel_read, accel_write;
   logic [31:0] accel_address, accel_st_data;
   logic        accel_resp;
   logic [31:0] accel_data;
   logic        dmem_read, dmem_write;
   logic [31:0] dmem_address, dmem_wdata;
   logic [3:0]  dmem_mbe;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;

   accel_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .lsq_read(lsq_read), .lsq_write(lsq_write), .lsq_address(lsq_address),
      .lsq_wdata(lsq_wdata), .lsq_mbe(lsq_mbe), .lsq_resp(lsq_resp), .lsq_rdata(lsq_rdata),
      .accel_read(accel_read), .accel_write(accel_write), .accel_address(accel_address),
      .accel_st_data(accel_st_data), .accel_resp(accel_resp), .accel_data(accel_data),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
      .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_resp(dmem_resp),
      .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: one in-flight transaction described by its fields
   bit          busy, resp_due, post_resp;
   int          owner;               // 0 = LSQ, 1 = accel
   logic        e_rd, e_wr;
   logic [31:0] e_addr, e_wdata, e_rdata;
   logic [3:0]  e_mbe;
   int          dc_cnt;
   bit          lsq_out, accel_out, lsq_done_now, accel_done_now;
   int          lsq_wait, accel_wait;
   int          order_q[$];
`ifdef ACCEL_MEM_ARB_RR_EN
   bit          last_accel;
`endif

   // stimulus knobs
   bit          rand_en, force_drop, force_data_en;
   int          force_lat;
   logic [31:0] force_data;

   task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      busy = 0; resp_due = 0; post_resp = 0; dc_cnt = 0;
      lsq_out = 0; accel_out = 0; lsq_wait = 0; accel_wait = 0;
      lsq_read = 0; lsq_write = 0; accel_read = 0; accel_write = 0;
      dmem_resp = 0;
`ifdef ACCEL_MEM_ARB_RR_EN
      last_accel = 1;
`endif
   endtask

   task automatic issue_lsq(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      lsq_write = wr; lsq_read = ~wr; lsq_address = a; lsq_wdata = d; lsq_mbe = m;
      lsq_out = 1; lsq_wait = 0;
   endtask

   task automatic issue_accel(input logic wr, input logic [31:0] a, input logic [31:0] d);
      accel_write = wr; accel_read = ~wr; accel_address = a; accel_st_data = d;
      accel_out = 1; accel_wait = 0;
   endtask

   // one clock: observe at negedge, check against model, then drive next inputs
   task automatic step();
      logic lp, ap;
      @(negedge clk);
      lsq_done_now = 0; accel_done_now = 0;
      check_val("lsq_resp", lsq_resp, resp_due && owner == 0);
      check_val("accel_resp", accel_resp, resp_due && owner == 1);
      if (resp_due) begin
         if (e_rd) check_val("rdata", owner == 1 ? accel_data : lsq_rdata, e_rdata);
         check_val("dmem_drop_after_resp", {dmem_read, dmem_write}, 2'b00);
         if (lsq_resp) order_q.push_back(0);
         else if (accel_resp) order_q.push_back(1);
         if (owner == 0) begin
            lsq_read = 0; lsq_write = 0; lsq_out = 0; lsq_done_now = 1;
         end else begin
            accel_read = 0; accel_write = 0; accel_out = 0; accel_done_now = 1;
         end
         resp_due = 0; busy = 0; post_resp = 1;
      end else if (post_resp) begin
         check_val("no_regrant_in_resp", {dmem_read, dmem_write}, 2'b00);
         post_resp = 0;
      end else if (busy) begin
         check_val("dmem_hold", {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe},
                   {e_rd, e_wr, e_addr, e_wdata, e_mbe});
      end else if (dmem_read || dmem_write) begin
         lp = lsq_read | lsq_write;
         ap = accel_read | accel_write;
         if (!lp && !ap) begin
            check_val("spurious_grant", {dmem_read, dmem_write}, 2'b00);
         end else begin
            if (lp && ap) begin
`ifdef ACCEL_MEM_ARB_RR_EN
               owner = last_accel ? 0 : 1;
`else
               owner = 0;
`endif
            end else begin
               owner = lp ? 0 : 1;
            end
`ifdef ACCEL_MEM_ARB_RR_EN
            last_accel = (owner == 1);
`endif
            if (owner == 0) begin
               e_wr = lsq_write; e_rd = lsq_read & ~lsq_write;
               e_addr = lsq_address; e_wdata = lsq_wdata; e_mbe = lsq_mbe;
            end else begin
               e_wr = accel_write; e_rd = accel_read & ~accel_write;
               e_addr = accel_address & 32'hFFFF_FFFC; e_wdata = accel_st_data; e_mbe = 4'hF;
            end
            check_val("grant_fields", {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe},
                      {e_rd, e_wr, e_addr, e_wdata, e_mbe});
            busy = 1;
            dc_cnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 12));
            if (owner == 1 && (force_drop || (rand_en && $urandom_range(0, 3) == 0))) begin
               accel_read = 0; accel_write = 0;
            end
         end
      end

      // dcache responder
      dmem_resp = 0;
      dmem_rdata = $urandom;
      if (busy && !resp_due) begin
         if (rand_en && $urandom_range(0, 2) == 0) begin
            if (owner == 0) begin lsq_address = $urandom; lsq_wdata = $urandom; end
            else begin accel_address = $urandom; accel_st_data = $urandom; end
         end
         dc_cnt--;
         if (dc_cnt == 0) begin
            dmem_resp = 1;
            if (force_data_en) dmem_rdata = force_data;
            e_rdata = dmem_rdata;
            resp_due = 1;
         end
      end

      // initiators: bounded wait, then random new requests
      if (lsq_out) begin
         lsq_wait++;
         if (lsq_wait == WAIT_MAX) begin
            check_val("lsq_wait_bound", lsq_wait, WAIT_MAX - 1);
            lsq_read = 0; lsq_write = 0; lsq_out = 0;
         end
      end
      if (accel_out) begin
         accel_wait++;
         if (accel_wait == WAIT_MAX) begin
            check_val("accel_wait_bound", accel_wait, WAIT_MAX - 1);
            accel_read = 0; accel_write = 0; accel_out = 0;
         end
      end
      if (rand_en) begin
         if (!lsq_out && !lsq_done_now && $urandom_range(0, 2) == 0)
            issue_lsq(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
         if (!accel_out && !accel_done_now && $urandom_range(0, 2) == 0)
            issue_accel(1'($urandom_range(0, 1)), $urandom, $urandom);
      end
   endtask

   task automatic run_until_idle(input int max_cycles);
      int n;
      n = 0;
      while ((busy || resp_due || lsq_out || accel_out) && n < max_cycles) begin
         step();
         n++;
      end
      check_val("reached_idle", {busy, resp_due, lsq_out, accel_out}, 4'b0000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1;
      rand_en = 0; force_drop = 0; force_data_en = 0; force_lat = 0; force_data = '0;
      lsq_address = '0; lsq_wdata = '0; lsq_mbe = '0;
      accel_address = '0; accel_st_data = '0; dmem_rdata = '0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      check_val("reset_outputs",
                {lsq_resp, lsq_rdata, accel_resp, accel_data, dmem_read, dmem_write,
                 dmem_address, dmem_wdata, dmem_mbe}, '0);
      reset = 0;

      // accel word read with byte offset, 1-cycle dcache
      force_lat = 1; force_data_en = 1; force_data = 32'hDEAD_BEEF;
      issue_accel(1'b0, 32'h0000_1006, 32'h0);
      run_until_idle(40);
      force_data_en = 0;

      // LSQ partial write with a 10-cycle dcache
      force_lat = 10;
      issue_lsq(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
      run_until_idle(40);

      // simultaneous requests, twice
      force_lat = 0;
      order_q.delete();
      issue_lsq(1'b0, 32'h0000_3000, 32'h0, 4'hF);
      issue_accel(1'b0, 32'h0000_4000, 32'h0);
      run_until_idle(80);
      issue_lsq(1'b0, 32'h0000_3004, 32'h0, 4'hF);
      issue_accel(1'b1, 32'h0000_4004, 32'hCAFE_F00D);
      run_until_idle(80);
      check_val("order_len", order_q.size(), 4);
      if (order_q.size() == 4) begin
         check_val("order_first", order_q[0], 0);
         check_val("order_second", order_q[1], 1);
         check_val("order_third", order_q[2], 0);
      end

      // accelerator withdraws its read right after the grant
      force_drop = 1; force_lat = 3;
      issue_accel(1'b0, 32'h0000_5008, 32'h0);
      run_until_idle(40);
      force_drop = 0;

      // reset while the dcache is still working
      force_lat = 8;
      issue_accel(1'b1, 32'h0000_6000, 32'h5555_AAAA);
      for (int i = 0; i < 4; i++) step();
      check_val("busy_before_reset", dmem_write, 1'b1);
      reset = 1;
      model_clear();
      step();
      check_val("reset_mid_outputs",
                {lsq_resp, lsq_rdata, accel_resp, accel_data, dmem_read, dmem_write,
                 dmem_address, dmem_wdata, dmem_mbe}, '0);
      reset = 0;
      for (int i = 0; i < 12; i++) step();
      force_lat = 2;
      issue_accel(1'b0, 32'h0000_7003, 32'h0);
      run_until_idle(40);

      // random traffic
      force_lat = 0;
      rand_en = 1;
      for (int i = 0; i < 2500; i++) step();
      rand_en = 0;
      run_until_idle(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
